// File: rtl/regfile_dump_unit_if.sv
// rtl/regfile_dump_unit_if.sv - framed byte stream plus register-bank read port bundle
interface regfile_dump_unit_if #(
   parameter int ADDR_W = 5
);
   logic [7:0]        tx_data;
   logic              tx_valid;
   logic              tx_ready;
   logic [ADDR_W-1:0] rd_addr;
   logic [31:0]       rd_data;

   modport master (
      output tx_data, tx_valid, rd_addr,
      input  tx_ready, rd_data
   );

   modport slave (
      input  tx_data, tx_valid, rd_addr,
      output tx_ready, rd_data
   );
endinterface

// File: rtl/regfile_dump_unit.sv
// rtl/regfile_dump_unit.sv - post-halt register-file dump engine producing a framed byte stream
// Optional trailing XOR checksum byte enabled by defining DUMP_CHECKSUM_EN.
module regfile_dump_unit #(
   parameter int         NUM_REGS   = 32,
   parameter int         ADDR_W     = 5,
   parameter logic [7:0] START_BYTE = 8'hA5
) (
   input  logic                 clk1,
   input  logic                 reset,
   input  logic                 halted,
   input  logic                 start,
   regfile_dump_unit_if.master  bus,
   output logic                 busy,
   output logic                 done
);

   typedef enum logic [3:0] {
      S_IDLE,
      S_SOF,
      S_FETCH,
      S_IDX,
      S_B3,
      S_B2,
      S_B1,
      S_B0,
`ifdef DUMP_CHECKSUM_EN
      S_CSUM,
`endif
      S_DONE
   } state_t;

   state_t            state;
   logic              halted_q;
   logic [ADDR_W-1:0] idx;
   logic [31:0]       shreg;
`ifdef DUMP_CHECKSUM_EN
   logic [7:0]        csum;
`endif

   logic accept;
   logic trigger;
   logic last_reg;

   assign accept   = bus.tx_valid & bus.tx_ready;
   assign trigger  = (halted & ~halted_q) | start;
   assign last_reg = (idx == ADDR_W'(NUM_REGS - 1));

   always_ff @(posedge clk1 or posedge reset) begin
      if (reset) begin
         state        <= S_IDLE;
         halted_q     <= 1'b0;
         idx          <= '0;
         shreg        <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         bus.tx_valid <= 1'b0;
         bus.tx_data  <= '0;
         bus.rd_addr  <= '0;
`ifdef DUMP_CHECKSUM_EN
         csum         <= '0;
`endif
      end else begin
         halted_q <= halted;
         done     <= 1'b0;
         case (state)
            S_IDLE: begin
               if (trigger) begin
                  state        <= S_SOF;
                  busy         <= 1'b1;
                  bus.tx_valid <= 1'b1;
                  bus.tx_data  <= START_BYTE;
               end
            end
            S_SOF: begin
               if (accept) begin
                  state        <= S_FETCH;
                  bus.tx_valid <= 1'b0;
                  bus.rd_addr  <= idx;
               end
            end
            // rd_data is combinational from rd_addr, which has been stable for this whole cycle
            S_FETCH: begin
               shreg        <= bus.rd_data;
               bus.tx_data  <= 8'(idx);
               bus.tx_valid <= 1'b1;
               state        <= S_IDX;
            end
            S_IDX, S_B3, S_B2, S_B1: begin
               if (accept) begin
                  bus.tx_data <= shreg[31:24];
                  shreg       <= {shreg[23:0], 8'h00};
`ifdef DUMP_CHECKSUM_EN
                  csum        <= csum ^ bus.tx_data;
`endif
                  state <= (state == S_IDX) ? S_B3 :
                           (state == S_B3)  ? S_B2 :
                           (state == S_B2)  ? S_B1 : S_B0;
               end
            end
            S_B0: begin
               if (accept) begin
                  if (last_reg) begin
`ifdef DUMP_CHECKSUM_EN
                     bus.tx_data <= csum ^ bus.tx_data;
                     csum        <= csum ^ bus.tx_data;
                     state       <= S_CSUM;
`else
                     bus.tx_valid <= 1'b0;
                     done         <= 1'b1;
                     state        <= S_DONE;
`endif
                  end else begin
`ifdef DUMP_CHECKSUM_EN
                     csum         <= csum ^ bus.tx_data;
`endif
                     idx          <= idx + ADDR_W'(1);
                     bus.rd_addr  <= idx + ADDR_W'(1);
                     bus.tx_valid <= 1'b0;
                     state        <= S_FETCH;
                  end
               end
            end
`ifdef DUMP_CHECKSUM_EN
            S_CSUM: begin
               if (accept) begin
                  bus.tx_valid <= 1'b0;
                  done         <= 1'b1;
                  state        <= S_DONE;
               end
            end
`endif
            S_DONE: begin
               busy  <= 1'b0;
               idx   <= '0;
`ifdef DUMP_CHECKSUM_EN
               csum  <= '0;
`endif
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_regfile_dump_unit.sv
// tb/tb_regfile_dump_unit.sv - scoreboard bench for regfile_dump_unit
module tb_regfile_dump_unit;
   localparam int NUM_REGS = 32;
   localparam int ADDR_W   = 5;
`ifdef DUMP_CHECKSUM_EN
   localparam int FRAME_LEN = 2 + 5 * NUM_REGS;
   localparam int DONE_LAT  = 194;
`else
   localparam int FRAME_LEN = 1 + 5 * NUM_REGS;
   localparam int DONE_LAT  = 193;
`endif

   logic clk1   = 1'b0;
   logic reset  = 1'b1;
   logic halted = 1'b0;
   logic start  = 1'b0;
   logic busy;
   logic done;

   regfile_dump_unit_if #(.ADDR_W(ADDR_W)) bus ();

   regfile_dump_unit #(
      .NUM_REGS  (NUM_REGS),
      .ADDR_W    (ADDR_W),
      .START_BYTE(8'hA5)
   ) dut (
      .clk1  (clk1),
      .reset (reset),
      .halted(halted),
      .start (start),
      .bus   (bus),
      .busy  (busy),
      .done  (done)
   );

   logic [31:0] regb [NUM_REGS];
   logic [7:0]  exp_q [$];
   int  checks   = 0;
   int  errors   = 0;
   int  nbytes   = 0;
   int  done_cnt = 0;
   int  cyc      = 0;
   int  trig_cyc = 0;
   bit  rand_ready = 1'b0;

   assign bus.rd_data = regb[bus.rd_addr];

   always #5 clk1 = ~clk1;
   always @(posedge clk1) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Reference frame: start marker, then per register its index and big-endian word, XOR trailer.
   task automatic push_frame();
      logic [7:0]  cs;
      logic [7:0]  b;
      logic [31:0] w;
      cs = 8'h00;
      exp_q.push_back(8'hA5);
      for (int i = 0; i < NUM_REGS; i++) begin
         b = 8'(i);
         exp_q.push_back(b);
         cs ^= b;
         w = regb[i];
         for (int k = 0; k < 4; k++) begin
            b = w[31 - 8 * k -: 8];
            exp_q.push_back(b);
            cs ^= b;
         end
      end
`ifdef DUMP_CHECKSUM_EN
      exp_q.push_back(cs);
`endif
   endtask

   task automatic pulse_start();
      @(posedge clk1);
      #1;
      start    = 1'b1;
      trig_cyc = cyc + 1;
      @(posedge clk1);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input string name, input int max_cyc, output int lat);
      int n;
      n   = 0;
      lat = -1;
      while (n < max_cyc) begin
         @(negedge clk1);
         if (done === 1'b1) begin
            lat = cyc - trig_cyc;
            break;
         end
         n++;
      end
      if (lat < 0) begin
         checks++;
         errors++;
         $display("FAIL %s actual=timeout expected=done", name);
      end
   endtask

   initial begin
      bus.tx_ready = 1'b1;
      forever begin
         @(posedge clk1);
         #1;
         bus.tx_ready = rand_ready ? ($urandom_range(0, 9) < 3) : 1'b1;
      end
   end

   // Monitor: pops expected bytes on every transfer and checks hold-while-stalled.
   initial begin
      logic       prev_valid;
      logic       prev_ready;
      logic [7:0] prev_data;
      prev_valid = 1'b0;
      prev_ready = 1'b0;
      prev_data  = 8'h00;
      forever begin
         @(negedge clk1);
         if (reset) begin
            prev_valid = 1'b0;
         end else begin
            if (prev_valid && !prev_ready) begin
               chk("hold_valid", 32'(bus.tx_valid), 32'd1);
               chk("hold_data", 32'(bus.tx_data), 32'(prev_data));
            end
            if (bus.tx_valid && bus.tx_ready) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_byte actual=%0h expected=none", bus.tx_data);
               end else begin
                  chk($sformatf("byte%0d", nbytes), 32'(bus.tx_data), 32'(exp_q.pop_front()));
               end
               nbytes++;
            end
            if (done) done_cnt++;
            prev_valid = bus.tx_valid;
            prev_ready = bus.tx_ready;
            prev_data  = bus.tx_data;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int dc0;
      int n;

      for (int i = 0; i < NUM_REGS; i++) regb[i] = 32'(i);
      repeat (3) @(negedge clk1);
      chk("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
      chk("rst_tx_data", 32'(bus.tx_data), 32'd0);
      chk("rst_rd_addr", 32'(bus.rd_addr), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      reset = 1'b0;
      repeat (3) @(posedge clk1);
      #1;
      chk("idle_busy", 32'(busy), 32'd0);

      // T1: halted rising edge, identity register contents
      push_frame();
      nbytes   = 0;
      halted   = 1'b1;
      trig_cyc = cyc + 1;
      wait_done("t1_done", 3000, lat);
      chk("t1_latency", 32'(lat), 32'(DONE_LAT));
      chk("t1_len", 32'(nbytes), 32'(FRAME_LEN));
      chk("t1_queue", 32'(exp_q.size()), 32'd0);
      @(negedge clk1);
      chk("t1_busy_after", 32'(busy), 32'd0);
      chk("t1_done_after", 32'(done), 32'd0);

      // T2: start pulse, a few registers altered
      @(posedge clk1);
      #1;
      halted  = 1'b0;
      regb[1] = 32'd5;
      regb[2] = 32'd15;
      regb[3] = 32'd20;
      regb[4] = 32'd20;
      regb[5] = 32'd15;
      push_frame();
      nbytes = 0;
      pulse_start();
      wait_done("t2_done", 3000, lat);
      chk("t2_latency", 32'(lat), 32'(DONE_LAT));
      chk("t2_len", 32'(nbytes), 32'(FRAME_LEN));

      // T3: same registers, sink stalls ~70% of cycles
      repeat (3) @(posedge clk1);
      rand_ready = 1'b1;
      push_frame();
      nbytes = 0;
      pulse_start();
      wait_done("t3_done", 5000, lat);
      chk("t3_len", 32'(nbytes), 32'(FRAME_LEN));
      rand_ready = 1'b0;

      // T4: further triggers while busy are ignored
      repeat (3) @(posedge clk1);
      for (int i = 0; i < NUM_REGS; i++) regb[i] = $urandom;
      dc0 = done_cnt;
      push_frame();
      nbytes = 0;
      pulse_start();
      repeat (10) @(posedge clk1);
      #1;
      start = 1'b1;
      @(posedge clk1);
      #1;
      start  = 1'b0;
      halted = 1'b1;
      wait_done("t4_done", 3000, lat);
      repeat (30) @(negedge clk1);
      chk("t4_done_count", 32'(done_cnt - dc0), 32'd1);
      chk("t4_busy_after", 32'(busy), 32'd0);
      chk("t4_valid_after", 32'(bus.tx_valid), 32'd0);
      chk("t4_queue", 32'(exp_q.size()), 32'd0);

      // T5: reset during B2 of register 7 with halted still high
      for (int i = 0; i < NUM_REGS; i++) regb[i] = $urandom;
      push_frame();
      nbytes = 0;
      pulse_start();
      n = 0;
      while (nbytes < 39 && n < 1000) begin
         @(negedge clk1);
         #2;
         n++;
      end
      chk("t5_reached_b2", 32'(nbytes), 32'd39);
      chk("t5_b2_byte", 32'(bus.tx_data), 32'(regb[7][23:16]));
      reset = 1'b1;
      #1;
      chk("t5_abort_valid", 32'(bus.tx_valid), 32'd0);
      chk("t5_abort_busy", 32'(busy), 32'd0);
      exp_q.delete();
      @(negedge clk1);
      push_frame();
      nbytes   = 0;
      reset    = 1'b0;
      trig_cyc = cyc + 1;
      wait_done("t5_done", 3000, lat);
      chk("t5_latency", 32'(lat), 32'(DONE_LAT));
      chk("t5_len", 32'(nbytes), 32'(FRAME_LEN));
      chk("t5_queue", 32'(exp_q.size()), 32'd0);
      repeat (5) @(negedge clk1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
